// File: rtl/day_pkg.sv
// Shared types, day codes and glyph table for the day-of-week select/display path.
package day_pkg;

  typedef logic [2:0] day_t;

  localparam day_t MON = 3'd0;
  localparam day_t TUE = 3'd1;
  localparam day_t WED = 3'd2;
  localparam day_t THU = 3'd3;
  localparam day_t FRI = 3'd4;
  localparam day_t SAT = 3'd5;
  localparam day_t SUN = 3'd6;

  // Segments {A,B,C,D,E,F,G}, bit 6 = A; code 7 is unreachable and stays dark.
  localparam logic [6:0] GLYPH [0:7] = '{
    7'b0011101, 7'b0111110, 7'b1001111, 7'b0110111,
    7'b0000110, 7'b1110000, 7'b1110110, 7'b0000000
  };

  typedef enum logic {ST_RUN, ST_SET} state_t;

  function automatic day_t day_inc(input day_t d);
    return (d == SUN) ? MON : day_t'(d + 3'd1);
  endfunction

  function automatic day_t day_dec(input day_t d);
    return (d == MON) ? SUN : day_t'(d - 3'd1);
  endfunction

endpackage

// File: rtl/day_glyph_rom.sv
// Pure lookup from day code and blink phase to a polarity-adjusted 7-segment glyph.
module day_glyph_rom
  import day_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  day_t       code,
  input  logic       blink_on,
  output logic [6:0] glyph
);

  logic [6:0] raw;

  always_comb begin
    raw   = blink_on ? GLYPH[code] : 7'b0000000;
    glyph = ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/day_select_ctrl.sv
// Day-of-week register with RUN (tick-advanced) and SET (up/down, blinking) modes,
// driving a registered 7-segment glyph for the third display digit.
module day_select_ctrl
  import day_pkg::*;
#(
  parameter int unsigned START_DAY   = 0,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned SET_TIMEOUT = 0,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       dn_btn,
  output logic [2:0] day,
  output logic       set_active,
  output logic       week_wrap,
  output logic [6:0] seg
);

  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int TO_W    = (SET_TIMEOUT > 0) ? $clog2(SET_TIMEOUT + 1) : 1;

  localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [TO_W-1:0]    TO_MAX     = (SET_TIMEOUT > 0) ? TO_W'(SET_TIMEOUT - 1) : '0;
  localparam day_t               START_CODE = day_t'(START_DAY);

  state_t             state_q,    state_d;
  day_t               day_q,      day_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
  logic               wrap_q,     wrap_d;
  logic               set_q;
  logic [6:0]         seg_q;

  day_t       rom_day;
  logic       rom_on;
  logic [6:0] rom_glyph;

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    day_d       = day_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    to_cnt_d    = to_cnt_q;
    wrap_d      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        to_cnt_d    = '0;
        if (mode_btn) begin
          state_d = ST_SET;
        end else if (day_tick) begin
          day_d  = day_inc(day_q);
          wrap_d = (day_q == SUN);
        end
      end

      ST_SET: begin
        if (mode_btn) begin
          state_d     = ST_RUN;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
          to_cnt_d    = '0;
        end else if (up_btn || dn_btn) begin
          // A simultaneous up+down cancels out but still counts as user activity.
          if (up_btn && !dn_btn) day_d = day_inc(day_q);
          if (dn_btn && !up_btn) day_d = day_dec(day_q);
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
          to_cnt_d    = '0;
        end else begin
          if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          end
          if (SET_TIMEOUT > 0) begin
            if (to_cnt_q == TO_MAX) begin
              state_d     = ST_RUN;
              blink_cnt_d = '0;
              blink_on_d  = 1'b1;
              to_cnt_d    = '0;
            end else begin
              to_cnt_d = to_cnt_q + TO_W'(1);
            end
          end
        end
      end

      default: state_d = ST_RUN;
    endcase

    // The glyph register loads from next-state values so it stays aligned with day.
    rom_day = rst ? START_CODE : day_d;
    rom_on  = rst ? 1'b1 : blink_on_d;
  end

  day_glyph_rom #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_rom (
    .code    (rom_day),
    .blink_on(rom_on),
    .glyph   (rom_glyph)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      day_q       <= START_CODE;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      to_cnt_q    <= '0;
      wrap_q      <= 1'b0;
      set_q       <= 1'b0;
      seg_q       <= rom_glyph;
    end else begin
      state_q     <= state_d;
      day_q       <= day_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      to_cnt_q    <= to_cnt_d;
      wrap_q      <= wrap_d;
      set_q       <= (state_d == ST_SET);
      seg_q       <= rom_glyph;
    end
  end

  assign day        = day_q;
  assign set_active = set_q;
  assign week_wrap  = wrap_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_day_select_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_day_select_ctrl;

  logic clk;
  logic a_rst, a_tick, a_mode, a_up, a_dn;
  logic b_rst, b_tick, b_mode, b_up, b_dn;
  logic [2:0] a_day, b_day;
  logic       a_set, b_set, a_wrap, b_wrap;
  logic [6:0] a_seg, b_seg;

  typedef struct {
    int          which;
    string       name;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Unit A: active-high segments, no timeout.  Unit B: active-low segments, 10-cycle timeout.
  day_select_ctrl #(
    .START_DAY(2), .BLINK_DIV(4), .SET_TIMEOUT(0), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(a_rst), .day_tick(a_tick), .mode_btn(a_mode), .up_btn(a_up),
    .dn_btn(a_dn), .day(a_day), .set_active(a_set), .week_wrap(a_wrap), .seg(a_seg)
  );

  day_select_ctrl #(
    .START_DAY(2), .BLINK_DIV(4), .SET_TIMEOUT(10), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(b_rst), .day_tick(b_tick), .mode_btn(b_mode), .up_btn(b_up),
    .dn_btn(b_dn), .day(b_day), .set_active(b_set), .week_wrap(b_wrap), .seg(b_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] glyph_of(input int d);
    case (d)
      0: return 7'b0011101;
      1: return 7'b0111110;
      2: return 7'b1001111;
      3: return 7'b0110111;
      4: return 7'b0000110;
      5: return 7'b1110000;
      6: return 7'b1110110;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d, input bit on, input bit al);
    logic [6:0] g;
    g = on ? glyph_of(d) : 7'b0000000;
    return al ? ~g : g;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got day=%0d set=%b wrap=%b seg=%b, expected day=%0d set=%b wrap=%b seg=%b",
               name, act[11:9], act[8], act[7], act[6:0], exp[11:9], exp[8], exp[7], exp[6:0]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which == 0) check(e.name, {a_day, a_set, a_wrap, a_seg}, e.exp);
      else              check(e.name, {b_day, b_set, b_wrap, b_seg}, e.exp);
    end
  end

  task automatic step(input int which, input string name,
                      input bit r, input bit t, input bit m, input bit u, input bit d,
                      input int eday, input bit eset, input bit ewrap, input bit eon);
    exp_t e;
    @(negedge clk);
    if (which == 0) {a_rst, a_tick, a_mode, a_up, a_dn} = {r, t, m, u, d};
    else            {b_rst, b_tick, b_mode, b_up, b_dn} = {r, t, m, u, d};
    @(posedge clk);
    e.which = which;
    e.name  = name;
    e.exp   = {3'(eday), eset, ewrap, exp_seg(eday, eon, which == 1)};
    sb.push_back(e);
  endtask

  initial begin
    {a_rst, a_tick, a_mode, a_up, a_dn} = 5'b10000;
    {b_rst, b_tick, b_mode, b_up, b_dn} = 5'b10000;

    // Unit A: reset, RUN advance and week wrap, SET stepping and blink, mid-SET reset.
    step(0, "a_reset",          1, 0, 0, 0, 0, 2, 0, 0, 1);
    step(0, "a_reset_hold",     1, 0, 0, 0, 0, 2, 0, 0, 1);
    step(0, "a_tick_3",         0, 1, 0, 0, 0, 3, 0, 0, 1);
    step(0, "a_tick_4",         0, 1, 0, 0, 0, 4, 0, 0, 1);
    step(0, "a_tick_5",         0, 1, 0, 0, 0, 5, 0, 0, 1);
    step(0, "a_run_up_ignored", 0, 0, 0, 1, 0, 5, 0, 0, 1);
    step(0, "a_run_dn_ignored", 0, 0, 0, 0, 1, 5, 0, 0, 1);
    step(0, "a_tick_6",         0, 1, 0, 0, 0, 6, 0, 0, 1);
    step(0, "a_tick_wrap",      0, 1, 0, 0, 0, 0, 0, 1, 1);
    step(0, "a_wrap_one_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, "a_enter_set",      0, 0, 1, 0, 0, 0, 1, 0, 1);
    step(0, "a_set_dn_wrap",    0, 0, 0, 0, 1, 6, 1, 0, 1);
    step(0, "a_blink_on1",      0, 0, 0, 0, 0, 6, 1, 0, 1);
    step(0, "a_set_tick_drop",  0, 1, 0, 0, 0, 6, 1, 0, 1);
    step(0, "a_blink_on3",      0, 0, 0, 0, 0, 6, 1, 0, 1);
    step(0, "a_blink_off0",     0, 0, 0, 0, 0, 6, 1, 0, 0);
    step(0, "a_updn_pair",      0, 0, 0, 1, 1, 6, 1, 0, 1);
    step(0, "a_pair_on1",       0, 0, 0, 0, 0, 6, 1, 0, 1);
    step(0, "a_pair_on2",       0, 0, 0, 0, 0, 6, 1, 0, 1);
    step(0, "a_mode_up_exit",   0, 0, 1, 1, 0, 6, 0, 0, 1);
    step(0, "a_run_wrap2",      0, 1, 0, 0, 0, 0, 0, 1, 1);
    step(0, "a_enter_set2",     0, 0, 1, 0, 0, 0, 1, 0, 1);
    step(0, "a_s2_on1",         0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, "a_s2_on2",         0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, "a_s2_on3",         0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, "a_s2_off",         0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, "a_rst_mid_set",    1, 0, 0, 0, 0, 2, 0, 0, 1);
    step(0, "a_after_rst",      0, 0, 0, 0, 0, 2, 0, 0, 1);
    step(0, "a_run_after_rst",  0, 1, 0, 0, 0, 3, 0, 0, 1);

    // Unit B: inverted polarity and SET timeout, with and without an intervening up_btn.
    step(1, "b_reset",          1, 0, 0, 0, 0, 2, 0, 0, 1);
    step(1, "b_enter_set",      0, 0, 1, 0, 0, 2, 1, 0, 1);
    for (int k = 1; k <= 9; k++)
      step(1, $sformatf("b_idle_%0d", k), 0, 0, 0, 0, 0, 2, 1, 0, (k < 4) || (k >= 8));
    step(1, "b_timeout_exit",   0, 0, 0, 0, 0, 2, 0, 0, 1);
    step(1, "b_enter_set2",     0, 0, 1, 0, 0, 2, 1, 0, 1);
    for (int k = 1; k <= 7; k++)
      step(1, $sformatf("b_pre_up_%0d", k), 0, 0, 0, 0, 0, 2, 1, 0, k < 4);
    step(1, "b_up_cycle8",      0, 0, 0, 1, 0, 3, 1, 0, 1);
    for (int k = 1; k <= 9; k++)
      step(1, $sformatf("b_post_up_%0d", k), 0, 0, 0, 0, 0, 3, 1, 0, (k < 4) || (k >= 8));
    step(1, "b_timeout_exit2",  0, 0, 0, 0, 0, 3, 0, 0, 1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
